// File: rtl/mul_div_unit.sv
// Iterative 32x32 multiply / divide unit with HI/LO result registers (MIPS mult/div style).
// Optional build macro MULDIV_FAST_MUL_EN: single-cycle multiply path (IDLE->FIX->DONE).
module mul_div_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        MulMode,
    input  logic        MulStart,
    input  logic        MulSelHL,
    input  logic        MulWrite,
    input  logic        Sign,
    input  logic [31:0] OpA,
    input  logic [31:0] OpB,
    output logic        mulready,
    output logic [31:0] Result
);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t      state_reg, state_next;
    logic        mode_reg, neg_q_reg, neg_r_reg, dz_reg;
    logic [4:0]  count_reg;
    logic [31:0] a_reg, b_reg, work_hi_reg, work_lo_reg, hi_reg, lo_reg;

    logic [31:0] a_abs, b_abs;
    logic [32:0] mul_sum, div_shift, div_diff;
    logic        div_ok;
    logic [31:0] step_hi, step_lo;
    logic [63:0] prod_fix;
    logic [31:0] q_fix, r_fix;

    assign a_abs = (Sign && OpA[31]) ? -OpA : OpA;
    assign b_abs = (Sign && OpB[31]) ? -OpB : OpB;

    // Multiply: {work_hi, work_lo} shifts right, multiplier consumed from work_lo[0].
    // Divide: {work_hi, work_lo} shifts left, remainder in work_hi, quotient bits enter work_lo.
    assign mul_sum   = {1'b0, work_hi_reg} + (work_lo_reg[0] ? {1'b0, a_reg} : 33'd0);
    assign div_shift = {work_hi_reg, work_lo_reg[31]};
    assign div_diff  = div_shift - {1'b0, b_reg};
    assign div_ok    = ~div_diff[32];

    always_comb begin
        step_hi = mul_sum[32:1];
        step_lo = {mul_sum[0], work_lo_reg[31:1]};
        if (mode_reg) begin
            step_hi = div_ok ? div_diff[31:0] : div_shift[31:0];
            step_lo = {work_lo_reg[30:0], div_ok};
        end
    end

    // With a zero divisor the remainder path naturally returns |OpA| re-signed, i.e. OpA.
    assign prod_fix = neg_q_reg ? -{work_hi_reg, work_lo_reg} : {work_hi_reg, work_lo_reg};
    assign q_fix    = dz_reg ? 32'hFFFF_FFFF : (neg_q_reg ? -work_lo_reg : work_lo_reg);
    assign r_fix    = neg_r_reg ? -work_hi_reg : work_hi_reg;

`ifdef MULDIV_FAST_MUL_EN
    logic [63:0] fast_prod;
    assign fast_prod = {32'd0, a_abs} * {32'd0, b_abs};
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (MulStart) begin
`ifdef MULDIV_FAST_MUL_EN
                state_next = MulMode ? CALC : FIX;
`else
                state_next = CALC;
`endif
            end
            CALC: if (count_reg == 5'd31) state_next = FIX;
            FIX:  state_next = DONE;
            DONE: if (!MulStart) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_reg    <= 1'b0;
            neg_q_reg   <= 1'b0;
            neg_r_reg   <= 1'b0;
            dz_reg      <= 1'b0;
            count_reg   <= 5'd0;
            a_reg       <= 32'd0;
            b_reg       <= 32'd0;
            work_hi_reg <= 32'd0;
            work_lo_reg <= 32'd0;
            hi_reg      <= 32'd0;
            lo_reg      <= 32'd0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (MulStart) begin
                        mode_reg    <= MulMode;
                        neg_q_reg   <= Sign & (OpA[31] ^ OpB[31]);
                        neg_r_reg   <= Sign & OpA[31];
                        dz_reg      <= MulMode & (OpB == 32'd0);
                        count_reg   <= 5'd0;
                        a_reg       <= a_abs;
                        b_reg       <= b_abs;
                        work_hi_reg <= 32'd0;
                        work_lo_reg <= MulMode ? a_abs : b_abs;
`ifdef MULDIV_FAST_MUL_EN
                        if (!MulMode) {work_hi_reg, work_lo_reg} <= fast_prod;
`endif
                    end else if (MulWrite) begin
                        if (MulSelHL) hi_reg <= OpA;
                        else          lo_reg <= OpA;
                    end
                end
                CALC: begin
                    work_hi_reg <= step_hi;
                    work_lo_reg <= step_lo;
                    count_reg   <= count_reg + 5'd1;
                end
                FIX: begin
                    if (mode_reg) begin
                        hi_reg <= r_fix;
                        lo_reg <= q_fix;
                    end else begin
                        hi_reg <= prod_fix[63:32];
                        lo_reg <= prod_fix[31:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign mulready = (state_reg == DONE);
    assign Result   = MulSelHL ? hi_reg : lo_reg;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: vector table, scoreboard queue, and corner sequences.
module tb_mul_div_unit;

    logic        clk = 1'b0;
    logic        reset, MulMode, MulStart, MulSelHL, MulWrite, Sign;
    logic [31:0] OpA, OpB, Result;
    logic        mulready;

    always #5 clk = ~clk;

    mul_div_unit dut (
        .clk(clk), .reset(reset), .MulMode(MulMode), .MulStart(MulStart),
        .MulSelHL(MulSelHL), .MulWrite(MulWrite), .Sign(Sign),
        .OpA(OpA), .OpB(OpB), .mulready(mulready), .Result(Result)
    );

`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 2;
`else
    localparam int MUL_LAT = 34;
`endif
    localparam int DIV_LAT = 34;

    typedef struct {
        logic        mode;
        logic        sign;
        logic [31:0] a, b, hi, lo;
    } vec_t;

    typedef struct {
        logic [31:0] hi, lo;
    } exp_t;

    exp_t        sb_q[$];
    vec_t        tbl[16];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] cur_hi, cur_lo;

    function automatic logic [63:0] model(input logic mode, input logic sign,
                                          input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb;
        logic signed [31:0] qa, qb;
        if (!mode) begin
            if (sign) begin
                sa = {{32{a[31]}}, a};
                sb = {{32{b[31]}}, b};
                return sa * sb;
            end
            return {32'd0, a} * {32'd0, b};
        end
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (sign) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
            qa = a;
            qb = b;
            return {32'(qa % qb), 32'(qa / qb)};
        end
        return {a % b, a / b};
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic checkint(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic read_hl(output logic [31:0] hi, output logic [31:0] lo);
        MulSelHL = 1'b1;
        #1 hi = Result;
        MulSelHL = 1'b0;
        #1 lo = Result;
    endtask

    // wr=1 keeps MulWrite high through the whole operation; it must never land.
    task automatic run_op(input vec_t v, input int hold, input logic wr);
        int          edges;
        int          lat;
        exp_t        e;
        logic [31:0] hi, lo;
        MulMode  = v.mode;
        Sign     = v.sign;
        OpA      = v.a;
        OpB      = v.b;
        MulSelHL = 1'b1;
        MulWrite = wr;
        MulStart = 1'b1;
        sb_q.push_back('{hi: v.hi, lo: v.lo});
        lat   = v.mode ? DIV_LAT : MUL_LAT;
        edges = 0;
        do begin
            tick();
            edges++;
            if (edges == 1) begin
                read_hl(hi, lo);
                check32("old_hi_kept", hi, cur_hi);
                check32("old_lo_kept", lo, cur_lo);
            end
        end while (!mulready && edges < 100);
        checkint("latency", edges, lat);
        e = sb_q.pop_front();
        read_hl(hi, lo);
        check32("hi", hi, e.hi);
        check32("lo", lo, e.lo);
        $display("op mode=%0d sign=%0d a=%08h b=%08h -> hi=%08h lo=%08h edges=%0d",
                 v.mode, v.sign, v.a, v.b, hi, lo, edges);
        cur_hi = e.hi;
        cur_lo = e.lo;
        for (int i = 0; i < hold; i++) begin
            tick();
            checkint("hold_ready", int'(mulready), 1);
        end
        MulWrite = 1'b0;
        MulStart = 1'b0;
        tick();
        checkint("idle_after_drop", int'(mulready), 0);
        read_hl(hi, lo);
        check32("hi_after_drop", hi, cur_hi);
    endtask

    initial begin
        logic [31:0] hi, lo;
        logic [63:0] m;

        tbl[0]  = '{0, 1, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA};
        tbl[1]  = '{0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        tbl[2]  = '{1, 1, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        tbl[3]  = '{1, 0, 32'h0000_0064, 32'h0000_0000, 32'h0000_0064, 32'hFFFF_FFFF};
        tbl[4]  = '{1, 1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        tbl[5]  = '{1, 1, 32'hFFFF_FFF0, 32'h0000_0000, 32'hFFFF_FFF0, 32'hFFFF_FFFF};
        tbl[6]  = '{0, 0, 32'h0000_0003, 32'h0000_0004, 32'h0000_0000, 32'h0000_000C};
        tbl[7]  = '{0, 1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
        tbl[8]  = '{1, 0, 32'hFFFF_FFFF, 32'h0000_000A, 32'h0000_0005, 32'h1999_9999};
        tbl[9]  = '{1, 1, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
        tbl[10] = '{0, 0, 32'h1234_5678, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000};
        for (int i = 11; i < 16; i++) begin
            tbl[i].mode = 1'($urandom_range(0, 1));
            tbl[i].sign = 1'($urandom_range(0, 1));
            tbl[i].a    = $urandom;
            tbl[i].b    = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(1, 255)) : $urandom;
            m           = model(tbl[i].mode, tbl[i].sign, tbl[i].a, tbl[i].b);
            tbl[i].hi   = m[63:32];
            tbl[i].lo   = m[31:0];
        end

        reset = 1'b1; MulMode = 0; MulStart = 0; MulSelHL = 0; MulWrite = 0; Sign = 0;
        OpA = 0; OpB = 0;
        cur_hi = 0; cur_lo = 0;
        tick();
        tick();
        checkint("reset_ready", int'(mulready), 0);
        read_hl(hi, lo);
        check32("reset_hi", hi, 32'h0);
        check32("reset_lo", lo, 32'h0);
        reset = 1'b0;
        tick();

        // mthi / mtlo
        MulWrite = 1'b1; MulSelHL = 1'b1; OpA = 32'h1234_5678;
        tick();
        MulSelHL = 1'b0; OpA = 32'hCAFE_F00D;
        tick();
        MulWrite = 1'b0;
        MulSelHL = 1'b1;
        #1 check32("mthi", Result, 32'h1234_5678);
        $display("write hi=%08h", Result);
        MulSelHL = 1'b0;
        #1 check32("mtlo", Result, 32'hCAFE_F00D);
        $display("write lo=%08h", Result);
        cur_hi = 32'h1234_5678;
        cur_lo = 32'hCAFE_F00D;

        for (int i = 0; i < 16; i++) run_op(tbl[i], 0, 1'b0);

        // start beats a simultaneous write; writes outside IDLE are ignored
        run_op('{0, 0, 32'hDEAD_0000, 32'h0000_0000, 32'h0, 32'h0}, 0, 1'b1);

        // MulStart held past DONE must not restart
        run_op('{1, 0, 32'h0000_03E8, 32'h0000_0007, 32'h0000_0006, 32'h0000_008E}, 5, 1'b0);

        // reset in the middle of a divide
        MulMode = 1'b1; Sign = 1'b0; OpA = 32'd1000; OpB = 32'd3; MulStart = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        reset = 1'b1;
        #1 checkint("abort_ready", int'(mulready), 0);
        read_hl(hi, lo);
        check32("abort_hi", hi, 32'h0);
        check32("abort_lo", lo, 32'h0);
        $display("reset mid-divide hi=%08h lo=%08h", hi, lo);
        MulStart = 1'b0;
        tick();
        reset = 1'b0;
        cur_hi = 0;
        cur_lo = 0;
        run_op('{1, 1, 32'hFFFF_FF9C, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFF2}, 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
